// File: rtl/mips_mem_responder_pkg.sv
// Memory map, MMIO register offsets and status bit positions shared by the
// MIPS memory responder and its console FIFO.
package mips_mem_responder_pkg;

  localparam logic [31:0] TEXT_BASE  = 32'h0040_0000;
  localparam logic [31:0] DATA_BASE  = 32'h1001_0000;
  localparam logic [31:0] MMIO_BASE  = 32'hFFFF_0000;
  localparam logic [31:0] MMIO_BYTES = 32'h0000_0010;

  // MMIO word offsets, i.e. addr[3:2] inside the MMIO page
  localparam logic [1:0] MMIO_CONSOLE = 2'd0;
  localparam logic [1:0] MMIO_CYCLES  = 2'd1;
  localparam logic [1:0] MMIO_FAULT   = 2'd2;
  localparam logic [1:0] MMIO_RSVD    = 2'd3;

  localparam int FAULT_BITS   = 4;
  localparam int FS_FAULT     = 0;
  localparam int FS_UNALIGNED = 1;
  localparam int FS_UNMAPPED  = 2;
  localparam int FS_WP        = 3;

  localparam int CS_FULL      = 0;
  localparam int CS_EMPTY     = 1;
  localparam int CS_OVERFLOW  = 2;
  localparam int CS_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    REGION_NONE = 2'd0,
    REGION_TEXT = 2'd1,
    REGION_DATA = 2'd2,
    REGION_MMIO = 2'd3
  } region_e;

  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] bytes);
    return (addr >= base) && ((addr - base) < bytes);
  endfunction

endpackage

// File: rtl/mips_console_fifo.sv
// Synchronous FIFO for console TX bytes; a push while full is accepted only
// when a pop happens in the same cycle. No fall-through from push to head.
module mips_console_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == {CW{1'b0}});
  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

  // Qualify push/pop against occupancy
  always_comb begin
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
  end

  // Pointers and occupancy; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage is not reset; only occupied entries are ever observed
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-port responder: text/data RAMs, console/cycle/fault MMIO page.
// Define MIPS_MEM_TEXT_WP_EN to write-protect the text region.
module mips_mem_responder
  import mips_mem_responder_pkg::*;
#(
  parameter int TEXT_WORDS = 1024,
  parameter int DATA_WORDS = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wr_data,
  input  logic        mem_wr_ena,
  output logic [31:0] mem_rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        addr_fault
);

  localparam int TEXT_AW = $clog2(TEXT_WORDS);
  localparam int DATA_AW = $clog2(DATA_WORDS);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] TEXT_BYTES = 32'(4 * TEXT_WORDS);
  localparam logic [31:0] DATA_BYTES = 32'(4 * DATA_WORDS);

  logic [31:0]           text_ram [TEXT_WORDS];
  logic [31:0]           data_ram [DATA_WORDS];
  logic [31:0]           cycles_r;
  logic [FAULT_BITS-1:0] fault_r;
  logic [FAULT_BITS-1:0] fault_new_s;
  logic [FAULT_BITS-1:0] fault_next_s;
  logic                  overflow_r;

  region_e               region_s;
  logic                  aligned_s;
  logic                  valid_s;
  logic [TEXT_AW-1:0]    text_idx_s;
  logic [DATA_AW-1:0]    data_idx_s;
  logic [1:0]            mmio_reg_s;
  logic                  text_we_s;
  logic                  data_we_s;
  logic                  fifo_push_s;
  logic                  fifo_pop_s;
  logic                  fault_clr_s;
  logic                  wp_hit_s;
  logic                  overflow_set_s;
  logic [31:0]           console_status_s;
  logic [31:0]           rd_word_s;

  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [CNT_W-1:0]      fifo_count_s;
  logic [7:0]            fifo_head_s;

  mips_console_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_console_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push_s),
    .push_data (mem_wr_data[7:0]),
    .pop       (fifo_pop_s),
    .head      (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  assign fifo_pop_s = !fifo_empty_s && tx_ready;
  assign tx_valid   = !fifo_empty_s;
  assign tx_data    = fifo_empty_s ? 8'h00 : fifo_head_s;
  assign addr_fault = fault_r[FS_FAULT];

  // Region decode; RAM bases are aligned to their sizes so low address bits index directly
  always_comb begin
    if (in_window(mem_addr, TEXT_BASE, TEXT_BYTES)) begin
      region_s = REGION_TEXT;
    end else if (in_window(mem_addr, DATA_BASE, DATA_BYTES)) begin
      region_s = REGION_DATA;
    end else if (in_window(mem_addr, MMIO_BASE, MMIO_BYTES)) begin
      region_s = REGION_MMIO;
    end else begin
      region_s = REGION_NONE;
    end
    aligned_s  = (mem_addr[1:0] == 2'b00);
    valid_s    = aligned_s && (region_s != REGION_NONE);
    text_idx_s = mem_addr[TEXT_AW+1:2];
    data_idx_s = mem_addr[DATA_AW+1:2];
    mmio_reg_s = mem_addr[3:2];
  end

  // Write steering; faulting writes never reach any target
  always_comb begin
    text_we_s   = 1'b0;
    data_we_s   = 1'b0;
    fifo_push_s = 1'b0;
    fault_clr_s = 1'b0;
    wp_hit_s    = 1'b0;
    if (mem_wr_ena && valid_s) begin
      case (region_s)
`ifdef MIPS_MEM_TEXT_WP_EN
        REGION_TEXT: wp_hit_s = 1'b1;
`else
        REGION_TEXT: text_we_s = 1'b1;
`endif
        REGION_DATA: data_we_s = 1'b1;
        REGION_MMIO: begin
          case (mmio_reg_s)
            MMIO_CONSOLE: fifo_push_s = 1'b1;
            MMIO_FAULT:   fault_clr_s = mem_wr_data[0];
            default:      fifo_push_s = 1'b0;
          endcase
        end
        default: data_we_s = 1'b0;
      endcase
    end else begin
      data_we_s = 1'b0;
    end
  end

  // A clear in the same cycle as a new fault loses to the new bits
  always_comb begin
    fault_new_s               = {FAULT_BITS{1'b0}};
    fault_new_s[FS_UNALIGNED] = !aligned_s;
    fault_new_s[FS_UNMAPPED]  = (region_s == REGION_NONE);
    fault_new_s[FS_WP]        = wp_hit_s;
    fault_new_s[FS_FAULT]     = |fault_new_s[FAULT_BITS-1:1];
    if (fault_clr_s) begin
      fault_next_s = fault_new_s;
    end else begin
      fault_next_s = fault_r | fault_new_s;
    end
    overflow_set_s = fifo_push_s && fifo_full_s && !fifo_pop_s;
  end

  // Read mux, sampled into mem_rd_data at the next edge
  always_comb begin
    console_status_s                          = 32'h0000_0000;
    console_status_s[CS_FULL]                 = fifo_full_s;
    console_status_s[CS_EMPTY]                = fifo_empty_s;
    console_status_s[CS_OVERFLOW]             = overflow_r;
    console_status_s[CS_COUNT_LSB +: 8]       = 8'(fifo_count_s);
    rd_word_s = 32'h0000_0000;
    if (valid_s) begin
      case (region_s)
        REGION_TEXT: rd_word_s = text_ram[text_idx_s];
        REGION_DATA: rd_word_s = data_ram[data_idx_s];
        REGION_MMIO: begin
          case (mmio_reg_s)
            MMIO_CONSOLE: rd_word_s = console_status_s;
            MMIO_CYCLES:  rd_word_s = cycles_r;
            MMIO_FAULT:   rd_word_s = {{(32-FAULT_BITS){1'b0}}, fault_r};
            MMIO_RSVD:    rd_word_s = 32'h0000_0000;
            default:      rd_word_s = 32'h0000_0000;
          endcase
        end
        default: rd_word_s = 32'h0000_0000;
      endcase
    end else begin
      rd_word_s = 32'h0000_0000;
    end
  end

  // Registered read data, cycle counter, sticky fault and overflow flags
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd_data <= 32'h0000_0000;
      cycles_r    <= 32'h0000_0000;
      fault_r     <= {FAULT_BITS{1'b0}};
      overflow_r  <= 1'b0;
    end else begin
      mem_rd_data <= rd_word_s;
      cycles_r    <= cycles_r + 32'd1;
      fault_r     <= fault_next_s;
      if (overflow_set_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // RAM writes; read-first falls out of the registered read above, contents survive reset
  always_ff @(posedge clk) begin
    if (text_we_s) begin
      text_ram[text_idx_s] <= mem_wr_data;
    end
    if (data_we_s) begin
      data_ram[data_idx_s] <= mem_wr_data;
    end
  end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder; honours MIPS_MEM_TEXT_WP_EN for the text write test.
module tb_mips_mem_responder;

  localparam int FIFO_DEPTH = 8;
  localparam logic [31:0] IDLE_ADDR = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ena;
  logic [31:0] mem_rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        addr_fault;

  int checks = 0;
  int failures = 0;

  mips_mem_responder #(
    .TEXT_WORDS (1024),
    .DATA_WORDS (1024),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_ena  (mem_wr_ena),
    .mem_rd_data (mem_rd_data),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .addr_fault  (addr_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One bus cycle; outputs are sampled 1 ns after the edge
  task automatic acc(input logic [31:0] addr, input logic [31:0] wdata, input logic we);
    mem_addr    = addr;
    mem_wr_data = wdata;
    mem_wr_ena  = we;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    acc(IDLE_ADDR, 32'h0, 1'b0);
  endtask

  logic [7:0]  drain_exp [FIFO_DEPTH];
  logic [31:0] text_old;

  initial begin
    rst = 1'b1; tx_ready = 1'b0;
    mem_addr = IDLE_ADDR; mem_wr_data = 32'h0; mem_wr_ena = 1'b0;
    idle(); idle();
    check("rst_rd_data", mem_rd_data, 32'h0);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_addr_fault", {31'h0, addr_fault}, 32'h0);
    rst = 1'b0;

    // 1: data RAM write/read, read-first
    acc(32'h1001_0010, 32'hCAFE_F00D, 1'b1);
    acc(32'h1001_0010, 32'h0, 1'b0);
    check("data_rd", mem_rd_data, 32'hCAFE_F00D);
    acc(32'h1001_0010, 32'h1, 1'b1);
    acc(32'h1001_0010, 32'h2, 1'b1);
    check("read_first", mem_rd_data, 32'h1);
    acc(32'h1001_0010, 32'h0, 1'b0);
    check("after_write", mem_rd_data, 32'h2);

    // 2: console push 3 bytes, then drain
    acc(32'hFFFF_0000, 32'h41, 1'b1);
    acc(32'hFFFF_0000, 32'h42, 1'b1);
    acc(32'hFFFF_0000, 32'h43, 1'b1);
    acc(32'hFFFF_0000, 32'h0, 1'b0);
    check("status_occ3", mem_rd_data, 32'h0000_0300);
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("drain3_valid", {31'h0, tx_valid}, 32'h1);
      check("drain3_data", {24'h0, tx_data}, 32'h41 + i);
      idle();
    end
    check("drain3_empty", {31'h0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // 3: overflow, push+pop while full
    for (int i = 0; i <= FIFO_DEPTH; i++) begin
      acc(32'hFFFF_0000, 32'h50 + i, 1'b1);
    end
    acc(32'hFFFF_0000, 32'h0, 1'b0);
    check("status_full_ovf", mem_rd_data, 32'h0000_0805);
    tx_ready = 1'b1;
    acc(32'hFFFF_0000, 32'h60, 1'b1);
    tx_ready = 1'b0;
    acc(32'hFFFF_0000, 32'h0, 1'b0);
    check("status_pushpop_full", mem_rd_data, 32'h0000_0805);
    for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
      drain_exp[i] = 8'h51 + 8'(i);
    end
    drain_exp[FIFO_DEPTH-1] = 8'h60;
    tx_ready = 1'b1;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      check("drain_full_data", {24'h0, tx_data}, {24'h0, drain_exp[i]});
      idle();
    end
    check("drain_full_empty", {31'h0, tx_valid}, 32'h0);
    tx_ready = 1'b0;
    acc(32'hFFFF_0000, 32'h0, 1'b0);
    check("status_ovf_sticky", mem_rd_data, 32'h0000_0006);

    // 4: faults
    acc(32'h1001_0002, 32'h0, 1'b0);
    check("unaligned_rd", mem_rd_data, 32'h0);
    check("unaligned_flag", {31'h0, addr_fault}, 32'h1);
    acc(32'hFFFF_0008, 32'h0, 1'b0);
    check("fault_0x3", mem_rd_data, 32'h3);
    acc(32'h2000_0000, 32'h0, 1'b0);
    check("unmapped_rd", mem_rd_data, 32'h0);
    acc(32'hFFFF_0008, 32'h0, 1'b0);
    check("fault_0x7", mem_rd_data, 32'h7);
    acc(32'hFFFF_0008, 32'h1, 1'b1);
    acc(32'hFFFF_0008, 32'h0, 1'b0);
    check("fault_cleared", mem_rd_data, 32'h0);
    check("flag_cleared", {31'h0, addr_fault}, 32'h0);
    acc(32'hFFFF_0004, 32'hDEAD_BEEF, 1'b1);
    acc(32'hFFFF_000C, 32'h0, 1'b0);
    check("rsvd_zero", mem_rd_data, 32'h0);

    // 5: text region write
    acc(32'h0040_0000, 32'h0, 1'b0);
    text_old = mem_rd_data;
    acc(32'h0040_0000, 32'h1234_5678, 1'b1);
    acc(32'h0040_0000, 32'h0, 1'b0);
`ifdef MIPS_MEM_TEXT_WP_EN
    check("text_wp_word", mem_rd_data, text_old);
    acc(32'hFFFF_0008, 32'h0, 1'b0);
    check("text_wp_fault", mem_rd_data, 32'h9);
    acc(32'hFFFF_0008, 32'h1, 1'b1);
`else
    check("text_word", mem_rd_data, 32'h1234_5678);
    acc(32'hFFFF_0008, 32'h0, 1'b0);
    check("text_no_fault", mem_rd_data, 32'h0);
`endif

    // 6: reset mid-drain
    for (int i = 0; i < 4; i++) begin
      acc(32'hFFFF_0000, 32'h71 + i, 1'b1);
    end
    acc(32'h1001_0001, 32'h0, 1'b0);
    check("pre_rst_fault", {31'h0, addr_fault}, 32'h1);
    tx_ready = 1'b1;
    idle();
    check("mid_drain_data", {24'h0, tx_data}, 32'h72);
    rst = 1'b1;
    idle();
    check("rst_mid_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_mid_fault", {31'h0, addr_fault}, 32'h0);
    check("rst_mid_rd", mem_rd_data, 32'h0);
    rst = 1'b0;
    tx_ready = 1'b0;
    acc(32'hFFFF_0004, 32'h0, 1'b0);
    check("cycles_0", mem_rd_data, 32'h0);
    acc(32'hFFFF_0004, 32'h0, 1'b0);
    check("cycles_1", mem_rd_data, 32'h1);
    acc(32'hFFFF_0008, 32'h0, 1'b0);
    check("post_rst_fault", mem_rd_data, 32'h0);
    acc(32'hFFFF_0000, 32'h0, 1'b0);
    check("post_rst_status", mem_rd_data, 32'h0000_0002);
    acc(32'h1001_0010, 32'h0, 1'b0);
    check("ram_survives_rst", mem_rd_data, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
